// File: rtl/scff_chain_ctrl.sv
// Scan-chain (SCFF) self-test sequencer: injects a single 1 into the fabric scan chain and
// checks its arrival at the tail. Optional macro SCFF_CTRL_FLUSH_EN adds a zero-flush phase.
module scff_chain_ctrl #(
  parameter int SCANCHAIN_SIZE = 64,
  parameter int CNT_W          = 16
) (
  input  logic             op_clk,
  input  logic             greset,
  input  logic             start,
  input  logic             sc_tail,
  output logic             sc_head,
  output logic             test_en,
  output logic             io_isol_n,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [7:0]       err_count,
  output logic [CNT_W-1:0] fail_cycle
);

`ifdef SCFF_CTRL_FLUSH_EN
  localparam bit FLUSH_EN = 1'b1;
`else
  localparam bit FLUSH_EN = 1'b0;
`endif

  localparam logic [CNT_W-1:0] T_ZERO   = '0;
  localparam logic [CNT_W-1:0] T_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] T_N      = CNT_W'(SCANCHAIN_SIZE);
  localparam logic [CNT_W-1:0] T_N_M1   = CNT_W'(SCANCHAIN_SIZE - 1);
  localparam logic [CNT_W-1:0] T_N_P2   = CNT_W'(SCANCHAIN_SIZE + 2);
  localparam logic [CNT_W-1:0] ARM_LAST = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_FLUSH,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [7:0]       err_nxt;
  logic [CNT_W-1:0] fail_nxt;
  logic             mismatch;
  logic             sc_head_nxt;
  logic             test_en_nxt;
  logic             busy_nxt;
  logic             done_nxt;
  logic             pass_nxt;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Without the flush phase the chain may hold stale data, so only the
  // arrival cycle and the two trailing cycles can be judged.
  function automatic logic check_en(input logic [CNT_W-1:0] t);
    if (FLUSH_EN) return (t >= T_ONE) && (t <= T_N_P2);
    else          return (t >= T_N)   && (t <= T_N_P2);
  endfunction

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    err_nxt   = err_count;
    fail_nxt  = fail_cycle;
    mismatch  = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_nxt = S_ARM;
          cnt_nxt   = T_ZERO;
          err_nxt   = 8'd0;
          fail_nxt  = T_ZERO;
        end
      end
      S_ARM: begin
        if (cnt == ARM_LAST) begin
          cnt_nxt   = T_ZERO;
          state_nxt = FLUSH_EN ? S_FLUSH : S_SHIFT;
        end else begin
          cnt_nxt = cnt + T_ONE;
        end
      end
      S_FLUSH: begin
        if (cnt == T_N_M1) begin
          cnt_nxt   = T_ZERO;
          state_nxt = S_SHIFT;
        end else begin
          cnt_nxt = cnt + T_ONE;
        end
      end
      S_SHIFT: begin
        mismatch = check_en(cnt) && (sc_tail != (cnt == T_N));
        if (mismatch) begin
          err_nxt = sat_inc8(err_count);
          if (fail_cycle == T_ZERO) fail_nxt = cnt;
        end
        if (cnt == T_N_P2) begin
          cnt_nxt   = T_ZERO;
          state_nxt = S_DONE;
        end else begin
          cnt_nxt = cnt + T_ONE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
        cnt_nxt   = T_ZERO;
      end
    endcase
  end

  // Output decode from the next state so every output is a plain register.
  always_comb begin
    sc_head_nxt = (state_nxt == S_SHIFT) && (state != S_SHIFT);
    test_en_nxt = (state_nxt != S_IDLE);
    busy_nxt    = (state_nxt == S_ARM) || (state_nxt == S_FLUSH) ||
                  (state_nxt == S_SHIFT);
    done_nxt    = (state_nxt == S_DONE);
    pass_nxt    = done_nxt && (err_nxt == 8'd0);
  end

  always_ff @(posedge op_clk) begin
    if (greset) begin
      state      <= S_IDLE;
      cnt        <= T_ZERO;
      sc_head    <= 1'b0;
      test_en    <= 1'b0;
      io_isol_n  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_count  <= 8'd0;
      fail_cycle <= T_ZERO;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      sc_head    <= sc_head_nxt;
      test_en    <= test_en_nxt;
      io_isol_n  <= test_en_nxt;
      busy       <= busy_nxt;
      done       <= done_nxt;
      pass       <= pass_nxt;
      err_count  <= err_nxt;
      fail_cycle <= fail_nxt;
    end
  end

endmodule
